// File: rtl/ram_streamer_if.sv
// ram_streamer_if: bundles the write-data stream, the read-data stream and
// the single-port RAM bus used by ram_streamer.
//   s_data/s_valid/s_ready   write stream into the streamer
//   m_data/m_valid/m_ready   read stream out of the streamer
//   ram_load/ram_address/ram_in/ram_out   registered single-port RAM bus
// master = the streamer side, slave = the environment (source, sink, RAM).
interface ram_streamer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;

  modport master (
    input  s_data, s_valid, m_ready, ram_out,
    output s_ready, m_data, m_valid, ram_load, ram_address, ram_in
  );

  modport slave (
    output s_data, s_valid, m_ready, ram_out,
    input  s_ready, m_data, m_valid, ram_load, ram_address, ram_in
  );
endinterface

// File: rtl/ram_streamer.sv
// ram_streamer: moves a block of words between a valid/ready stream and a
// registered single-port RAM.
//   clock, reset     single clock, synchronous active-high reset
//   start/mode       command strobe (IDLE only); mode 0 = stream -> RAM,
//                    mode 1 = RAM -> stream
//   base/len         first word address and word count (0..32768)
//   busy/done        busy outside IDLE; done pulses for one cycle at the end
//   bus              streams and RAM bus (ram_streamer_if.master)
// Writes run at one word per cycle. Reads take three cycles per word:
// present the address, capture the registered RAM output, then hold it on
// the output stream until accepted.
module ram_streamer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       len,
  output logic              busy,
  output logic              done,
  ram_streamer_if.master    bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_ADDR = 3'd2;
  localparam logic [2:0] S_RD_CAP  = 3'd3;
  localparam logic [2:0] S_RD_OUT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [15:0]       cnt_q,    cnt_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    m_data_d = m_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base;
          cnt_d  = len;
          if (len == 16'd0)   state_d = S_DONE;
          else if (mode)      state_d = S_RD_ADDR;
          else                state_d = S_WR;
        end
      end

      S_WR: begin
        // s_ready is constantly high here, so s_valid alone is the handshake.
        if (bus.s_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_DONE;
        end
      end

      S_RD_ADDR: state_d = S_RD_CAP;

      S_RD_CAP: begin
        // The RAM registered the address during RD_ADDR; its output is
        // valid now and is held locally so m_data stays stable under stall.
        m_data_d = bus.ram_out;
        state_d  = S_RD_OUT;
      end

      S_RD_OUT: begin
        if (bus.m_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? S_DONE : S_RD_ADDR;
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign bus.s_ready     = (state_q == S_WR);
  assign bus.ram_load    = (state_q == S_WR) && bus.s_valid;
  assign bus.ram_in      = bus.s_data;
  assign bus.ram_address = addr_q;
  assign bus.m_valid     = (state_q == S_RD_OUT);
  assign bus.m_data      = m_data_q;

endmodule

// File: tb/tb_ram_streamer.sv
// tb_ram_streamer: directed bench for ram_streamer with a behavioural
// registered RAM attached to the RAM bus.
module tb_ram_streamer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        mode;
  logic [14:0] base;
  logic [15:0] len;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int wr_count;
  int done_count;

  logic [15:0] mem [0:32767];

  ram_streamer_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  ram_streamer #(.ADDR_W(15), .DATA_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .base  (base),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered single-port RAM: output is the word addressed last cycle.
  always @(posedge clock) begin
    if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    bus.ram_out <= mem[bus.ram_address];
  end

  // Count write cycles and done pulses away from the active edge.
  always @(negedge clock) begin
    if (bus.ram_load) wr_count++;
    if (done)         done_count++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    checks++; if (bus.m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data: got %h want 0000", bus.m_data); end
    checks++; if (bus.ram_load !== 1'b0) begin errors++; $display("FAIL reset_ram_load: got %b want 0", bus.ram_load); end
    checks++; if (bus.ram_address !== 15'h0000) begin errors++; $display("FAIL reset_ram_address: got %h want 0000", bus.ram_address); end
    reset = 1'b0;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write;
    logic [15:0] wdata [3];
    int w0;
    int d0;
    wdata[0] = 16'hAAAA; wdata[1] = 16'h5555; wdata[2] = 16'h1234;
    w0 = wr_count; d0 = done_count;
    start = 1'b1; mode = 1'b0; base = 15'h0010; len = 16'd3;
    step;
    start = 1'b0; base = 15'h0000; len = 16'd0;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = wdata[i]; bus.s_valid = 1'b1;
      #1;
      checks++; if (bus.ram_load !== 1'b1) begin errors++; $display("FAIL wr_load[%0d]: got %b want 1", i, bus.ram_load); end
      checks++; if (bus.ram_address !== 15'(16 + i)) begin errors++; $display("FAIL wr_addr[%0d]: got %h want %h", i, bus.ram_address, 15'(16 + i)); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL wr_s_ready[%0d]: got %b want 1", i, bus.s_ready); end
      checks++; if (bus.ram_in !== wdata[i]) begin errors++; $display("FAIL wr_ram_in[%0d]: got %h want %h", i, bus.ram_in, wdata[i]); end
      step;
    end
    bus.s_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wr_done_pulse: got done=%b busy=%b want 1 1", done, busy); end
    checks++; if (bus.ram_load !== 1'b0) begin errors++; $display("FAIL wr_done_load: got %b want 0", bus.ram_load); end
    step;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got done=%b busy=%b want 0 0", done, busy); end
    checks++; if (wr_count - w0 != 3) begin errors++; $display("FAIL wr_count: got %0d want 3", wr_count - w0); end
    checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL wr_done_count: got %0d want 1", done_count - d0); end
    checks++; if (mem[16] !== 16'hAAAA || mem[17] !== 16'h5555 || mem[18] !== 16'h1234) begin
      errors++; $display("FAIL wr_mem: got %h %h %h want aaaa 5555 1234", mem[16], mem[17], mem[18]);
    end
  endtask

  task automatic test_read_backpressure;
    logic [15:0] exp [3];
    int w0;
    int d0;
    int n;
    exp[0] = 16'hAAAA; exp[1] = 16'h5555; exp[2] = 16'h1234;
    w0 = wr_count; d0 = done_count;
    bus.m_ready = 1'b0;
    start = 1'b1; mode = 1'b1; base = 15'h0010; len = 16'd3;
    step;
    start = 1'b0; mode = 1'b0; base = 15'h0000; len = 16'd0;
    checks++; if (busy !== 1'b1 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL rd_addr_phase: got busy=%b m_valid=%b want 1 0", busy, bus.m_valid); end
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!bus.m_valid && n < 8) begin step; n++; end
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_timeout[%0d]: got %b want 1", i, bus.m_valid); end
      checks++; if (bus.m_data !== exp[i]) begin errors++; $display("FAIL rd_data[%0d]: got %h want %h", i, bus.m_data, exp[i]); end
      if (i == 1) begin
        for (int k = 0; k < 4; k++) begin
          step;
          checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp[1]) begin
            errors++; $display("FAIL rd_stall[%0d]: got valid=%b data=%h want 1 %h", k, bus.m_valid, bus.m_data, exp[1]);
          end
        end
      end
      bus.m_ready = 1'b1;
      step;
      bus.m_ready = 1'b0;
    end
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rd_done: got %b want 1", done); end
    step;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rd_idle: got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (wr_count != w0) begin errors++; $display("FAIL rd_no_write: got %0d writes want 0", wr_count - w0); end
    checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL rd_done_count: got %0d want 1", done_count - d0); end
  endtask

  task automatic test_wrap;
    start = 1'b1; mode = 1'b0; base = 15'h7FFF; len = 16'd2;
    step;
    start = 1'b0; base = 15'h0000; len = 16'd0;
    bus.s_data = 16'hBEEF; bus.s_valid = 1'b1;
    #1;
    checks++; if (bus.ram_address !== 15'h7FFF || bus.ram_load !== 1'b1) begin
      errors++; $display("FAIL wrap_first: got addr=%h load=%b want 7fff 1", bus.ram_address, bus.ram_load);
    end
    step;
    bus.s_data = 16'hCAFE;
    #1;
    checks++; if (bus.ram_address !== 15'h0000 || bus.ram_load !== 1'b1) begin
      errors++; $display("FAIL wrap_second: got addr=%h load=%b want 0000 1", bus.ram_address, bus.ram_load);
    end
    step;
    bus.s_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done); end
    step;
    checks++; if (mem[32767] !== 16'hBEEF || mem[0] !== 16'hCAFE) begin
      errors++; $display("FAIL wrap_mem: got %h %h want beef cafe", mem[32767], mem[0]);
    end
  endtask

  task automatic test_zero_len;
    int w0;
    w0 = wr_count;
    bus.s_valid = 1'b1; bus.s_data = 16'h7777;
    start = 1'b1; mode = 1'b0; base = 15'h0055; len = 16'd0;
    step;
    start = 1'b0; base = 15'h0000;
    checks++; if (busy !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL zero_done: got busy=%b done=%b want 1 1", busy, done); end
    checks++; if (bus.ram_load !== 1'b0 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL zero_no_access: got load=%b s_ready=%b want 0 0", bus.ram_load, bus.s_ready); end
    step;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy=%b done=%b want 0 0", busy, done); end
    bus.s_valid = 1'b0;
    checks++; if (wr_count != w0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_reset_mid_write;
    int w0;
    int d0;
    w0 = wr_count; d0 = done_count;
    start = 1'b1; mode = 1'b0; base = 15'h0100; len = 16'd10;
    step;
    start = 1'b0; base = 15'h0000; len = 16'd0;
    for (int i = 0; i < 4; i++) begin
      bus.s_data = 16'h1000 + 16'(i); bus.s_valid = 1'b1;
      step;
    end
    reset = 1'b1; bus.s_valid = 1'b0;
    step;
    reset = 1'b0; bus.s_valid = 1'b1; bus.s_data = 16'hFFFF;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_done: got %b %b want 0 0", busy, done); end
    checks++; if (bus.s_ready !== 1'b0 || bus.ram_load !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_handshake: got s_ready=%b load=%b m_valid=%b want 0 0 0", bus.s_ready, bus.ram_load, bus.m_valid);
    end
    checks++; if (bus.m_data !== 16'h0000 || bus.ram_address !== 15'h0000) begin
      errors++; $display("FAIL rst_mid_regs: got m_data=%h addr=%h want 0000 0000", bus.m_data, bus.ram_address);
    end
    step;
    step;
    bus.s_valid = 1'b0;
    checks++; if (wr_count - w0 != 4) begin errors++; $display("FAIL rst_mid_writes: got %0d want 4", wr_count - w0); end
    checks++; if (done_count != d0) begin errors++; $display("FAIL rst_mid_no_done: got %0d want 0", done_count - d0); end
    checks++; if (mem[259] !== 16'h1003 || mem[260] !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_mem: got %h %h want 1003 0000", mem[259], mem[260]);
    end
  endtask

  task automatic test_start_ignored;
    logic [15:0] got [4];
    int w0;
    int d0;
    int n;
    int nw;
    w0 = wr_count; d0 = done_count; nw = 0; n = 0;
    bus.m_ready = 1'b1;
    start = 1'b1; mode = 1'b1; base = 15'h0010; len = 16'd3;
    step;
    start = 1'b0; mode = 1'b0; base = 15'h0000; len = 16'd0;
    while (!done && n < 40) begin
      if (n == 4) begin start = 1'b1; base = 15'h0200; len = 16'd5; end
      if (n == 5) begin start = 1'b0; base = 15'h0000; len = 16'd0; end
      if (bus.m_valid && nw < 4) begin got[nw] = bus.m_data; nw++; end
      step;
      n++;
    end
    checks++; if (n != 9) begin errors++; $display("FAIL ign_cycles: got %0d want 9", n); end
    checks++; if (nw != 3) begin errors++; $display("FAIL ign_words: got %0d want 3", nw); end
    checks++; if (got[0] !== 16'hAAAA || got[1] !== 16'h5555 || got[2] !== 16'h1234) begin
      errors++; $display("FAIL ign_data: got %h %h %h want aaaa 5555 1234", got[0], got[1], got[2]);
    end
    // Start raised while in DONE must not launch a new transfer.
    start = 1'b1; mode = 1'b1; base = 15'h0010; len = 16'd3;
    step;
    start = 1'b0; mode = 1'b0; base = 15'h0000; len = 16'd0;
    bus.m_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_done_start: got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (done_count - d0 != 1 || wr_count != w0) begin
      errors++; $display("FAIL ign_counts: got done=%0d writes=%0d want 1 0", done_count - d0, wr_count - w0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; wr_count = 0; done_count = 0;
    for (int a = 0; a < 32768; a++) mem[a] = 16'h0000;
    reset = 1'b1; start = 1'b0; mode = 1'b0; base = '0; len = '0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    test_reset;
    test_write;
    test_read_backpressure;
    test_wrap;
    test_zero_len;
    test_reset_mid_write;
    test_start_ignored;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
